cpu_read_burst_gen: RTL and testbench

//  Generates the CPU read-burst handshake: one cpu_start pulse, exactly N
//  non-consecutive read_complete pulses, and a cpu_end pulse coincident with
//  the last read_complete. Producer side of the cpu_start/read_complete/cpu_end

---
 rtl/cpu_burst_pkg.sv | 20 ++
 rtl/cpu_gap_timer.sv | 34 +++
 rtl/cpu_read_burst_gen.sv | 108 ++++++++++
 tb/tb_cpu_read_burst_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_burst_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_burst_pkg : shared state encoding and default widths for the burst gen
// Rev 1.0
// ----------------------------------------------------------------------------
package cpu_burst_pkg;

   localparam int LEN_W_DEFAULT = 4;
   localparam int GAP_W_DEFAULT = 3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      GAP      = 3'd2,
      ISSUE    = 3'd3,
      COMPLETE = 3'd4
   } burst_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_gap_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_gap_timer : loadable down-counter timing the idle gap before each read
// Rev 1.0
// ----------------------------------------------------------------------------
module cpu_gap_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] value;

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (dec && (value != '0)) begin
         value <= value - W'(1);
      end
   end

   // Flags the decrement that brings the count to zero, so the caller can
   // leave the gap in the same cycle the count expires.
   assign zero = (value <= W'(1));

endmodule
`default_nettype wire

// File: rtl/cpu_read_burst_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_read_burst_gen : issues one memory read per gap, framing the burst with
// cpu_start / read_complete / cpu_end pulses.   Rev 1.0
// ----------------------------------------------------------------------------
module cpu_read_burst_gen
   import cpu_burst_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEFAULT,
   parameter int GAP_W = GAP_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [LEN_W-1:0] req_len,
   input  logic [GAP_W-1:0] req_gap,
   output logic             mem_rd_req,
   input  logic             mem_rd_ack,
   output logic             cpu_start,
   output logic             read_complete,
   output logic             cpu_end,
   output logic             busy,
   output logic             len0_err,
   output logic             ack_err
);

   burst_state_t     state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] done_cnt;
   logic [GAP_W-1:0] gap_q;
   logic             len0_q;
   logic             ack_err_q;

   logic             accept;
   logic             last_read;
   logic [GAP_W-1:0] gap_eff;
   logic             timer_load;
   logic             timer_zero;

   assign accept     = req_valid && (state == IDLE);
   assign last_read  = (done_cnt + LEN_W'(1)) == len_q;
   // A zero gap still gets one idle cycle so read_complete never repeats back-to-back.
   assign gap_eff    = (gap_q == '0) ? GAP_W'(1) : gap_q;
   assign timer_load = (state == START) || (state == COMPLETE);

   cpu_gap_timer #(
      .W (GAP_W)
   ) u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (gap_eff),
      .dec      (state == GAP),
      .zero     (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         len_q     <= '0;
         gap_q     <= '0;
         done_cnt  <= '0;
         len0_q    <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         len0_q    <= accept && (req_len == '0);
         ack_err_q <= mem_rd_ack && (state != ISSUE);
         case (state)
            IDLE: begin
               if (accept && (req_len != '0)) begin
                  len_q    <= req_len;
                  gap_q    <= req_gap;
                  done_cnt <= '0;
                  state    <= START;
               end
            end
            START: begin
               state <= GAP;
            end
            GAP: begin
               if (timer_zero) state <= ISSUE;
            end
            ISSUE: begin
               if (mem_rd_ack) state <= COMPLETE;
            end
            COMPLETE: begin
               done_cnt <= done_cnt + LEN_W'(1);
               state    <= last_read ? IDLE : GAP;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign req_ready     = (state == IDLE);
   assign busy          = (state != IDLE);
   assign cpu_start     = (state == START);
   assign mem_rd_req    = (state == ISSUE);
   assign read_complete = (state == COMPLETE);
   assign cpu_end       = (state == COMPLETE) && last_read;
   assign len0_err      = len0_q;
   assign ack_err       = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_read_burst_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cpu_read_burst_gen : randomized bursts checked against a cycle schedule
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cpu_read_burst_gen;
   import cpu_burst_pkg::*;

   localparam int LW = LEN_W_DEFAULT;
   localparam int GW = GAP_W_DEFAULT;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [LW-1:0] req_len = '0;
   logic [GW-1:0] req_gap = '0;
   logic          mem_rd_ack = 1'b0;
   logic          req_ready, mem_rd_req, cpu_start, read_complete, cpu_end;
   logic          busy, len0_err, ack_err;

   int total = 0;
   int bad   = 0;
   int mon_len = 0;
   int mon_cnt = 0;
   bit prev_rc = 1'b0;

   always #5 clk = ~clk;

   cpu_read_burst_gen #(
      .LEN_W (LW),
      .GAP_W (GW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_len       (req_len),
      .req_gap       (req_gap),
      .mem_rd_req    (mem_rd_req),
      .mem_rd_ack    (mem_rd_ack),
      .cpu_start     (cpu_start),
      .read_complete (read_complete),
      .cpu_end       (cpu_end),
      .busy          (busy),
      .len0_err      (len0_err),
      .ack_err       (ack_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Protocol monitor: pulse count between cpu_start and cpu_end equals len,
   // and read_complete never fires on consecutive cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (cpu_start) mon_cnt = 0;
         if (read_complete) begin
            check_eq("rc_consecutive", 32'(prev_rc), 32'(0));
            mon_cnt++;
         end
         if (cpu_end) check_eq("burst_pulse_count", 32'(mon_cnt), 32'(mon_len));
         prev_rc = read_complete;
      end
   end

   task automatic check_idle(input string tag);
      check_eq({tag, "_ready"}, 32'(req_ready), 32'(1));
      check_eq({tag, "_busy"}, 32'(busy), 32'(0));
      check_eq({tag, "_start"}, 32'(cpu_start), 32'(0));
      check_eq({tag, "_rc"}, 32'(read_complete), 32'(0));
      check_eq({tag, "_end"}, 32'(cpu_end), 32'(0));
      check_eq({tag, "_memreq"}, 32'(mem_rd_req), 32'(0));
   endtask

   // Entered and left at the negedge of an idle cycle. Each read k completes
   // at comp[k] = comp[k-1] + max(gap,1) + ack_delay + 2, counted from cpu_start.
   task automatic run_burst(input int len, input int gap, input int dmin, input int dmax,
                            input int abort_k);
      int g, t, endc;
      int comp[$];
      int dly[$];
      bit e_rc, e_req, ack_now;
      g = (gap == 0) ? 1 : gap;
      t = 0;
      for (int k = 0; k < len; k++) begin
         int d;
         d = int'($urandom_range(dmax, dmin));
         t = t + g + d + 2;
         comp.push_back(t);
         dly.push_back(d);
      end
      endc    = comp[len-1];
      mon_len = len;
      req_valid = 1'b1;
      req_len   = LW'(len);
      req_gap   = GW'(gap);
      for (int c = 0; c <= endc + 1; c++) begin
         @(negedge clk);
         if (c == 0) begin
            req_valid = 1'b0;
            req_len   = LW'($urandom);
            req_gap   = GW'($urandom);
         end
         e_rc = 1'b0; e_req = 1'b0; ack_now = 1'b0;
         foreach (comp[k]) begin
            if (c == comp[k]) e_rc = 1'b1;
            if (c >= comp[k] - dly[k] - 1 && c <= comp[k] - 1) e_req = 1'b1;
            if (c == comp[k] - 1) ack_now = 1'b1;
         end
         check_eq("cpu_start", 32'(cpu_start), 32'(c == 0));
         check_eq("read_complete", 32'(read_complete), 32'(e_rc));
         check_eq("cpu_end", 32'(cpu_end), 32'(c == endc));
         check_eq("mem_rd_req", 32'(mem_rd_req), 32'(e_req));
         check_eq("busy", 32'(busy), 32'(c <= endc));
         check_eq("req_ready", 32'(req_ready), 32'(c > endc));
         check_eq("ack_err_quiet", 32'(ack_err), 32'(0));
         check_eq("len0_err_quiet", 32'(len0_err), 32'(0));
         mem_rd_ack = ack_now;
         if (abort_k > 0 && c == comp[abort_k-1] + 1) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            mem_rd_ack = 1'b0;
            check_idle("abort");
            return;
         end
      end
      mem_rd_ack = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_idle("reset");
      check_eq("reset_len0", 32'(len0_err), 32'(0));
      check_eq("reset_ackerr", 32'(ack_err), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      run_burst(3, 1, 0, 0, 0);
      run_burst(2, 0, 0, 0, 0);
      run_burst(3, 2, 4, 4, 0);
      run_burst(4, 1, 0, 2, 2);
      run_burst(5, 3, 0, 1, 0);
      run_burst(15, 0, 0, 0, 0);
      run_burst(1, 7, 0, 3, 0);

      // zero-length request
      req_valid = 1'b1; req_len = '0; req_gap = 3'd3;
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("len0_pulse", 32'(len0_err), 32'(1));
      check_idle("len0");
      @(negedge clk);
      check_eq("len0_once", 32'(len0_err), 32'(0));
      check_idle("len0_after");

      // stray ack while idle
      mem_rd_ack = 1'b1;
      @(negedge clk);
      mem_rd_ack = 1'b0;
      check_eq("ackerr_pulse", 32'(ack_err), 32'(1));
      check_idle("ackerr");
      @(negedge clk);
      check_eq("ackerr_once", 32'(ack_err), 32'(0));
      check_idle("ackerr_after");

      for (int i = 0; i < 25; i++) begin
         int idle;
         idle = int'($urandom_range(2, 0));
         repeat (idle) begin
            @(negedge clk);
            check_idle("gap_idle");
         end
         run_burst(int'($urandom_range(15, 1)), int'($urandom_range(7, 0)),
                   0, int'($urandom_range(3, 0)), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
